// File: rtl/rect_fill_engine_if.sv
// Command and frame-store write bundle for rect_fill_engine.
//
// Handshake: iStart is a single-cycle command strobe. It is accepted only
// while oBusy=0, and everything else on the command side is sampled in that
// same cycle. oWren is a write strobe with no back-pressure. The memory
// controller takes one pixel on every clock edge that ends a cycle with
// oWren=1, and in that cycle oAddress, oData and oChipSelect are valid.
interface rect_fill_engine_if #(
    parameter int ADDR_W   = 17,
    parameter int COLOUR_W = 9
);
    // Command side
    logic                iStart;
    logic [8:0]          iX0;
    logic [8:0]          iX1;
    logic [7:0]          iY0;
    logic [7:0]          iY1;
    logic [COLOUR_W-1:0] iColour;
    logic                iLayer;
    logic                iAbort;

    // Memory-controller side and status
    logic [ADDR_W-1:0]   oAddress;
    logic [COLOUR_W-1:0] oData;
    logic                oWren;
    logic                oChipSelect;
    logic                oBusy;
    logic                oDone;

    // Debug view of the engine FSM state
    logic [1:0]          dbg_state;

    modport master (
        output iStart, iX0, iX1, iY0, iY1, iColour, iLayer, iAbort,
        input  oAddress, oData, oWren, oChipSelect, oBusy, oDone, dbg_state
    );

    modport slave (
        input  iStart, iX0, iX1, iY0, iY1, iColour, iLayer, iAbort,
        output oAddress, oData, oWren, oChipSelect, oBusy, oDone, dbg_state
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches a corner pair, normalises and clips it to
// the visible frame, then writes one pixel per clock in raster order to the
// frame store. All outputs are registered.
module rect_fill_engine #(
    parameter int H_RES    = 320,
    parameter int V_RES    = 240,
    parameter int ADDR_W   = 17,
    parameter int COLOUR_W = 9
) (
    input  logic               iClk,
    input  logic               iReset,
    rect_fill_engine_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0]        X_MAX    = 9'(H_RES - 1);
    localparam logic [7:0]        Y_MAX    = 8'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    // FSM and latched command
    logic [1:0]          state_q,  state_d;
    logic [8:0]          x0_q,     x0_d;
    logic [8:0]          x1_q,     x1_d;
    logic [7:0]          y0_q,     y0_d;
    logic [7:0]          y1_q,     y1_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                layer_q,  layer_d;

    // Normalised, clipped bounds and raster position
    logic [8:0]          xl_q,     xl_d;
    logic [8:0]          xr_q,     xr_d;
    logic [7:0]          yb_q,     yb_d;
    logic [8:0]          cur_x_q,  cur_x_d;
    logic [7:0]          cur_y_q,  cur_y_d;
    logic [ADDR_W-1:0]   row_q,    row_d;

    // Registered outputs
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [COLOUR_W-1:0] data_q,    data_d;
    logic                wren_q,    wren_d;
    logic                cs_q,      cs_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    // Setup arithmetic, only consumed in SETUP
    logic [8:0]          xl_c;
    logic [8:0]          xr_c;
    logic [7:0]          yt_c;
    logic [7:0]          yb_c;
    logic [ADDR_W-1:0]   base_c;
    logic                last_pixel;

    // Normalise corners, clip to the visible frame and form the first row base.
    // The row base uses yt*320 = yt*256 + yt*64 so no multiplier is needed.
    always_comb begin
        xl_c = (x0_q < x1_q) ? x0_q : x1_q;
        xr_c = (x0_q < x1_q) ? x1_q : x0_q;
        yt_c = (y0_q < y1_q) ? y0_q : y1_q;
        yb_c = (y0_q < y1_q) ? y1_q : y0_q;
        if (xl_c > X_MAX) xl_c = X_MAX;
        if (xr_c > X_MAX) xr_c = X_MAX;
        if (yt_c > Y_MAX) yt_c = Y_MAX;
        if (yb_c > Y_MAX) yb_c = Y_MAX;
        base_c = (ADDR_W'(yt_c) << 8) + (ADDR_W'(yt_c) << 6);
    end

    assign last_pixel = (cur_x_q == xr_q) && (cur_y_q == yb_q);

    // Next-state logic. In FILL, the output registers already present the
    // current pixel, so this cycle decides what (if anything) comes next.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        colour_d  = colour_q;
        layer_d   = layer_q;
        xl_d      = xl_q;
        xr_d      = xr_q;
        yb_d      = yb_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        row_d     = row_q;
        address_d = address_q;
        data_d    = data_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.iStart) begin
                    x0_d     = bus.iX0;
                    x1_d     = bus.iX1;
                    y0_d     = bus.iY0;
                    y1_d     = bus.iY1;
                    colour_d = bus.iColour;
                    layer_d  = bus.iLayer;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end

            S_SETUP: begin
                xl_d      = xl_c;
                xr_d      = xr_c;
                yb_d      = yb_c;
                cur_x_d   = xl_c;
                cur_y_d   = yt_c;
                row_d     = base_c;
                address_d = base_c + ADDR_W'(xl_c);
                data_d    = colour_q;
                cs_d      = layer_q;
                wren_d    = 1'b1;
                state_d   = S_FILL;
            end

            S_FILL: begin
                if (bus.iAbort || last_pixel) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cur_x_q == xr_q) begin
                    cur_x_d   = xl_q;
                    cur_y_d   = cur_y_q + 8'd1;
                    row_d     = row_q + ROW_STEP;
                    address_d = row_q + ROW_STEP + ADDR_W'(xl_q);
                    wren_d    = 1'b1;
                end else begin
                    cur_x_d   = cur_x_q + 9'd1;
                    address_d = row_q + ADDR_W'(cur_x_q) + ADDR_W'(1);
                    wren_d    = 1'b1;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything, including abort.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            colour_q  <= '0;
            layer_q   <= 1'b0;
            xl_q      <= '0;
            xr_q      <= '0;
            yb_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            row_q     <= '0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            colour_q  <= colour_d;
            layer_q   <= layer_d;
            xl_q      <= xl_d;
            xr_q      <= xr_d;
            yb_q      <= yb_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            row_q     <= row_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.oAddress    = address_q;
    assign bus.oData       = data_q;
    assign bus.oWren       = wren_q;
    assign bus.oChipSelect = cs_q;
    assign bus.oBusy       = busy_q;
    assign bus.oDone       = done_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed testbench for rect_fill_engine: a table of fill commands with
// hand-computed results, plus hand-written held-start and mid-fill reset runs.
module tb_rect_fill_engine;

    localparam int ADDR_W   = 17;
    localparam int COLOUR_W = 9;

    logic clk;
    logic rst;

    rect_fill_engine_if #(.ADDR_W(ADDR_W), .COLOUR_W(COLOUR_W)) bus ();

    rect_fill_engine #(
        .H_RES(320), .V_RES(240), .ADDR_W(ADDR_W), .COLOUR_W(COLOUR_W)
    ) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    logic [ADDR_W-1:0] exp_q[$];

    typedef struct {
        string             name;
        logic [8:0]        x0;
        logic [8:0]        x1;
        logic [7:0]        y0;
        logic [7:0]        y1;
        logic [8:0]        colour;
        logic              layer;
        int                abort_at;   // abort in the cycle of this write (0 = never)
        int                exp_count;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference raster: min/max, clamp, then y*320+x in plain integer maths.
    task automatic model_fill(input int x0, input int x1, input int y0, input int y1);
        int xl, xr, yt, yb;
        xl = (x0 < x1) ? x0 : x1;
        xr = (x0 < x1) ? x1 : x0;
        yt = (y0 < y1) ? y0 : y1;
        yb = (y0 < y1) ? y1 : y0;
        if (xl > 319) xl = 319;
        if (xr > 319) xr = 319;
        if (yt > 239) yt = 239;
        if (yb > 239) yb = 239;
        for (int y = yt; y <= yb; y++)
            for (int x = xl; x <= xr; x++)
                exp_q.push_back(ADDR_W'(y * 320 + x));
    endtask

    task automatic idle_inputs();
        bus.iStart  = 1'b0;
        bus.iX0     = '0;
        bus.iX1     = '0;
        bus.iY0     = '0;
        bus.iY1     = '0;
        bus.iColour = '0;
        bus.iLayer  = 1'b0;
        bus.iAbort  = 1'b0;
    endtask

    // Driver: issue one command in cycle 0 and follow it to completion.
    task automatic run_vec(input vec_t v);
        int cyc, nw, done_cyc;
        logic [ADDR_W-1:0] first_a, last_a, exp_a;
        exp_q.delete();
        model_fill(int'(v.x0), int'(v.x1), int'(v.y0), int'(v.y1));
        first_a = '0;
        last_a  = '0;
        @(negedge clk);
        bus.iX0     = v.x0;
        bus.iX1     = v.x1;
        bus.iY0     = v.y0;
        bus.iY1     = v.y1;
        bus.iColour = v.colour;
        bus.iLayer  = v.layer;
        bus.iStart  = 1'b1;
        cyc = 0;
        nw = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.iAbort = 1'b0;
            if (cyc == 1) begin
                bus.iStart = 1'b0;
                check({v.name, "_busy_c1"}, 32'(bus.oBusy), 1);
                check({v.name, "_wren_c1"}, 32'(bus.oWren), 0);
            end
            if (bus.oWren) begin
                if (nw == 0) first_a = bus.oAddress;
                last_a = bus.oAddress;
                check({v.name, "_write_cycle"}, cyc, nw + 2);
                if (exp_q.size() > 0) begin
                    exp_a = exp_q.pop_front();
                    check({v.name, "_addr"}, 32'(bus.oAddress), 32'(exp_a));
                end else begin
                    check({v.name, "_extra_write"}, 32'(bus.oAddress), 32'hFFFF_FFFF);
                end
                check({v.name, "_data"}, 32'(bus.oData), 32'(v.colour));
                check({v.name, "_cs"}, 32'(bus.oChipSelect), 32'(v.layer));
                nw++;
                if (v.abort_at != 0 && nw == v.abort_at) bus.iAbort = 1'b1;
            end
            if (bus.oDone) begin
                done_cyc = cyc;
                check({v.name, "_wren_in_done"}, 32'(bus.oWren), 0);
            end
        end
        bus.iAbort = 1'b0;
        if (done_cyc < 0) check({v.name, "_done_timeout"}, 0, 1);
        check({v.name, "_count"}, nw, v.exp_count);
        check({v.name, "_first"}, 32'(first_a), 32'(v.exp_first));
        check({v.name, "_last"}, 32'(last_a), 32'(v.exp_last));
        check({v.name, "_done_cycle"}, done_cyc, v.exp_count + 2);
        @(negedge clk);
        check({v.name, "_done_pulse"}, 32'(bus.oDone), 0);
        check({v.name, "_busy_after"}, 32'(bus.oBusy), 0);
    endtask

    initial begin
        int cyc, nw;
        bit seen;
        n_vec = 0;
        n_err = 0;

        // name, x0, x1, y0, y1, colour, layer, abort_at, count, first, last
        vecs[0] = '{"sq2x2",    9'd1,   9'd2,   8'd1,   8'd2,   9'h1FF, 1'b1, 0, 4, 17'd321,   17'd642};
        vecs[1] = '{"swapped",  9'd2,   9'd1,   8'd2,   8'd1,   9'h0AA, 1'b0, 0, 4, 17'd321,   17'd642};
        // y=300 does not fit the 8-bit port; 255 is past V_RES-1 just the same
        vecs[2] = '{"clip",     9'd318, 9'd400, 8'd238, 8'd255, 9'h123, 1'b1, 0, 4, 17'd76478, 17'd76799};
        vecs[3] = '{"single",   9'd0,   9'd0,   8'd0,   8'd0,   9'h001, 1'b0, 0, 1, 17'd0,     17'd0};
        vecs[4] = '{"abort3",   9'd0,   9'd9,   8'd0,   8'd1,   9'h0F0, 1'b1, 3, 3, 17'd0,     17'd2};
        vecs[5] = '{"rect3x3",  9'd12,  9'd10,  8'd100, 8'd98,  9'h055, 1'b0, 0, 9, 17'd31370, 17'd32012};
        vecs[6] = '{"offscr",   9'd350, 9'd511, 8'd250, 8'd255, 9'h1C7, 1'b1, 0, 1, 17'd76799, 17'd76799};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_addr",  32'(bus.oAddress), 0);
        check("rst_data",  32'(bus.oData), 0);
        check("rst_wren",  32'(bus.oWren), 0);
        check("rst_cs",    32'(bus.oChipSelect), 0);
        check("rst_busy",  32'(bus.oBusy), 0);
        check("rst_done",  32'(bus.oDone), 0);
        check("rst_state", 32'(bus.dbg_state), 0);

        // abort outside FILL must not matter
        bus.iAbort = 1'b1;
        @(negedge clk);
        bus.iAbort = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Held iStart: 10x1 at row 5, then retrigger only after oBusy falls
        @(negedge clk);
        bus.iX0 = 9'd9; bus.iX1 = 9'd0; bus.iY0 = 8'd5; bus.iY1 = 8'd5;
        bus.iColour = 9'h0C3; bus.iLayer = 1'b1; bus.iStart = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 11) begin
                check("hold_wren", 32'(bus.oWren), 1);
                check("hold_addr", 32'(bus.oAddress), 32'(1600 + c - 2));
            end
            if (c == 1 || c == 12) check("hold_busy_on", 32'(bus.oBusy), 1);
            if (c == 12) begin
                check("hold_done", 32'(bus.oDone), 1);
                check("hold_wren_off", 32'(bus.oWren), 0);
            end
            if (c == 13) check("hold_busy_gap", 32'(bus.oBusy), 0);
            if (c == 14) check("hold_retrigger", 32'(bus.oBusy), 1);
            if (c == 15) check("hold_rerun_addr", 32'(bus.oAddress), 1600);
        end
        bus.iStart = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.oDone) seen = 1'b1;
        end
        check("hold_rerun_done", 32'(seen), 1);
        @(negedge clk);

        // Reset in the middle of FILL
        bus.iX0 = 9'd0; bus.iX1 = 9'd9; bus.iY0 = 8'd0; bus.iY1 = 8'd1;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        cyc = 0;
        nw = 0;
        while (nw < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.oWren) nw++;
        end
        check("rst_mid_reached", nw, 5);
        rst = 1'b1;
        bus.iAbort = 1'b1;   // reset must win over abort
        @(negedge clk);
        rst = 1'b0;
        bus.iAbort = 1'b0;
        check("rst_mid_wren",  32'(bus.oWren), 0);
        check("rst_mid_busy",  32'(bus.oBusy), 0);
        check("rst_mid_addr",  32'(bus.oAddress), 0);
        check("rst_mid_state", 32'(bus.dbg_state), 0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.oDone || bus.oWren) seen = 1'b1;
        end
        check("rst_mid_quiet", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Drawing-side engine that fills an axis-aligned rectangle of one colour into the pixel frame store. It sits directly upstream of the memory controller and drives its address, data, write-enable and chip-select inputs. It emits one pixel write per clock until the rectangle is complete. Corners are normalised and the rectangle is clipped to the visible frame. The target layer (memory bank) is chosen per command.

## Interface
- H_RES, 320, visible width in pixels; address = y*H_RES + x
- V_RES, 240, visible height in pixels
- ADDR_W, 17, frame-store address width
- COLOUR_W, 9, pixel width (RGB 3:3:3)

- iClk  in  1  system clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  command strobe, sampled only in IDLE
- iX0, iX1  in  9 each  corner x coordinates, any order
- iY0, iY1  in  8 each  corner y coordinates, any order
- iColour  in  COLOUR_W  fill colour
- iLayer  in  1  target bank, copied to oChipSelect
- iAbort  in  1  stop fill after current cycle
- oAddress  out  ADDR_W  pixel address to memory controller
- oData  out  COLOUR_W  pixel data to memory controller
- oWren  out  1  write strobe, one pixel per high cycle
- oChipSelect  out  1  bank select to memory controller
- oBusy  out  1  command in progress
- oDone  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, FILL, DONE.
- **IDLE:**
  - If iStart=1, latch the command (x0, x1, y0, y1, colour, layer) and go to SETUP.
  - iStart is ignored in every other state.
- **SETUP:**
  - Normalise: xl=min(x0,x1), xr=max(x0,x1); same for y into yt/yb.
  - Clip: any coordinate ≥ H_RES clamps to H_RES-1; any coordinate ≥ V_RES clamps to V_RES-1.
  - Compute row base = yt*H_RES as (yt<<8)+(yt<<6), valid for H_RES=320. No multiplier is required.
  - Go to FILL.
- **FILL:**
  - One write per cycle in raster order: x from xl to xr, then row base += H_RES, y+1, x = xl.
  - oAddress = row base + x, at full ADDR_W width with no truncation (max 76799).
  - oData = latched colour; oChipSelect = latched layer; oWren=1.
  - After the write at (xr, yb), go to DONE.
  - iAbort=1 during FILL: the write presented in that cycle completes, then go to DONE with no further writes.
- **DONE:** oDone=1 for one cycle, then go to IDLE.
- oBusy=1 in SETUP, FILL and DONE; 0 in IDLE.
- Pixel count = (xr-xl+1)*(yb-yt+1). A degenerate rectangle (x0=x1, y0=y1) writes exactly 1 pixel.
- A fully off-screen command clips to the edge pixel(s). No empty-rectangle case exists.

## Timing
- All outputs are registered.
- Reset values: oAddress=0, oData=0, oWren=0, oChipSelect=0, oBusy=0, oDone=0, state=IDLE.
- Latency, with iStart sampled high at the edge ending cycle 0:
  - oBusy=1 from cycle 1.
  - First oWren=1 in cycle 2.
  - N writes occupy cycles 2..N+1, back-to-back with no gaps.
  - oDone=1 in cycle N+2.
  - oBusy=0 and a new iStart is accepted from cycle N+3.
- The memory controller captures each write on the edge ending the cycle in which oWren=1.
- oWren is never high outside FILL.
- oAddress, oData and oChipSelect are don't-care when oWren=0, but hold their last value.
- iReset=1 in any state, including mid-FILL: on the next edge all outputs return to reset values and no further writes are issued. The partially filled rectangle remains in memory.
- iAbort and iReset in the same cycle: iReset wins.
- iAbort outside FILL has no effect.

## Test plan
- Rectangle (1,1)-(2,2), colour 9'h1FF, layer 1, start in cycle 0:
  - writes to 321, 322, 641, 642 in cycles 2-5;
  - oData=9'h1FF and oChipSelect=1 on every write;
  - oDone pulses in cycle 6.
- Swapped corners (2,2)-(1,1), layer 0: same four addresses in the same order, oChipSelect=0.
- Clipping (318,238)-(400,300):
  - exactly 4 writes, to 76478, 76479, 76798, 76799;
  - no address exceeds 76799.
- Single pixel (0,0): one write to address 0 in cycle 2; oDone in cycle 3.
- 10×1 fill at row 5 with iStart held high throughout:
  - 10 contiguous writes, 1600..1609;
  - the held iStart re-triggers only after oBusy falls.
- Robustness:
  - iAbort asserted in the 3rd write cycle: exactly 3 writes, then oDone.
  - Separate run with iReset mid-FILL: oWren=0 and oBusy=0 on the next edge, and no oDone pulse.
